// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60Hz timing constants shared by the sync generator, painter and bench.
// Derived totals and sync windows are inclusive pixel/line positions.
package vga_timing_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  localparam int CW = 10;
  typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the sync generator to the painter/connector.
// Signals: pixel_tick (pixel strobe), pixel_x/pixel_y (counters), hsync/vsync (active low),
// video_on (visible area). master drives, slave consumes.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;
  logic pixel_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic hsync;
  logic vsync;
  logic video_on;
  modport master(output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on);
  modport slave(input pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on);
endinterface

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: divides the board clock into a registered one-clk pixel strobe.
// Ports: clk, reset_n (async, active low), tick (high for one clk every CLK_DIV clks).
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic tick_q, tick_d;
  always_comb begin
    tick_d = div_q == DW'(CLK_DIV - 1);
    div_d = tick_d ? '0 : div_q + DW'(1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (pixel counters, hsync/vsync, video_on).
// Ports: clk, reset_n (async, active low), vga (vga_sync_gen_if.master bundle).
// Build option VGA_SYNC_ALIGN_EN: delays hsync/vsync/video_on by one pixel to line up
// with a painter that registers its RGB output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK
) (
  input logic clk,
  input logic reset_n,
  vga_sync_gen_if.master vga
);
  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS0 = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS1 = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS0 = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS1 = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  if (HT > 1024 || VT > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be >= 1");
  end
  logic tick;
  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick)
  );
  coord_t x_q, x_d, y_q, y_d;
  logic hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic x_end;
  // Decodes look at the next counter values and are only refreshed on a tick, so the
  // reset state (blanked at 0,0) survives until the first pixel advance.
  always_comb begin
    x_end = x_q == H_LAST;
    x_d = tick ? (x_end ? '0 : x_q + coord_t'(1)) : x_q;
    y_d = tick && x_end ? (y_q == V_LAST ? '0 : y_q + coord_t'(1)) : y_q;
    hs_d = tick ? !(x_d >= HS0 && x_d <= HS1) : hs_q;
    vs_d = tick ? !(y_d >= VS0 && y_d <= VS1) : vs_q;
    von_d = tick ? (x_d < H_VIS && y_d < V_VIS) : von_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      von_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      von_q <= von_d;
    end
  end
  assign vga.pixel_tick = tick;
  assign vga.pixel_x = x_q;
  assign vga.pixel_y = y_q;
`ifdef VGA_SYNC_ALIGN_EN
  logic hs_a_q, vs_a_q, von_a_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_a_q <= 1'b1;
      vs_a_q <= 1'b1;
      von_a_q <= 1'b0;
    end else if (tick) begin
      hs_a_q <= hs_q;
      vs_a_q <= vs_q;
      von_a_q <= von_q;
    end
  end
  assign vga.hsync = hs_a_q;
  assign vga.vsync = vs_a_q;
  assign vga.video_on = von_a_q;
`else
  assign vga.hsync = hs_q;
  assign vga.vsync = vs_q;
  assign vga.video_on = von_q;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed self-checking bench for vga_sync_gen (default and CLK_DIV=1 instances).
module tb_vga_sync_gen;
  import vga_timing_pkg::*;
  localparam int FVT = 10;
`ifdef VGA_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vga_sync_gen_if vif ();
  vga_sync_gen_if fif ();
  vga_sync_gen #(.CLK_DIV(2)) u_dut (
    .clk(clk),
    .reset_n(rst_n),
    .vga(vif)
  );
  vga_sync_gen #(
    .CLK_DIV(1),
    .V_DISPLAY(4),
    .V_FRONT(2),
    .V_SYNC(2),
    .V_BACK(2)
  ) u_fast (
    .clk(clk),
    .reset_n(rst_n),
    .vga(fif)
  );
  int ediv, ex, ey;
  logic etick, eh, ev, evo, ah, av, avo;
  task automatic model_reset();
    ediv = 0;
    etick = 1'b0;
    ex = 0;
    ey = 0;
    eh = 1'b1;
    ev = 1'b1;
    evo = 1'b0;
    ah = 1'b1;
    av = 1'b1;
    avo = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    if (etick) begin
      ah = eh;
      av = ev;
      avo = evo;
      ex = ex == H_TOTAL - 1 ? 0 : ex + 1;
      if (ex == 0) ey = ey == V_TOTAL - 1 ? 0 : ey + 1;
      eh = !(ex >= H_SYNC_START && ex <= H_SYNC_END);
      ev = !(ey >= V_SYNC_START && ey <= V_SYNC_END);
      evo = ex < H_DISPLAY && ey < V_DISPLAY;
    end
    etick = ediv == 1;
    ediv = ediv == 1 ? 0 : ediv + 1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    logic [22:0] got, exp;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    model_reset();
    got = {vif.pixel_tick, vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.video_on};
    exp = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, exp);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (vif.pixel_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick_clk1: got %b expected 0", vif.pixel_tick);
    end
    step();
    checks++;
    if (vif.pixel_tick !== 1'b1 || vif.pixel_x !== 10'd0) begin
      errors++;
      $display("FAIL reset_tick_clk2: tick %b x %0d expected tick 1 x 0", vif.pixel_tick, vif.pixel_x);
    end
    step();
    checks++;
    if (vif.pixel_tick !== 1'b0 || vif.pixel_x !== 10'd1 || vif.video_on !== !ALIGN) begin
      errors++;
      $display("FAIL reset_first_pixel: tick %b x %0d von %b expected tick 0 x 1 von %b",
               vif.pixel_tick, vif.pixel_x, vif.video_on, !ALIGN);
    end
  endtask
  task automatic test_line();
    int hs_fall = -1, hs_rise = -1, von_fall = -1, px, n = 0;
    logic ph, pv, wrapped = 1'b0;
    logic [22:0] got, exp;
    ph = vif.hsync;
    pv = vif.video_on;
    px = int'(vif.pixel_x);
    while (!wrapped && n < 2000) begin
      step();
      n++;
      got = {vif.pixel_tick, vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.video_on};
      exp = {etick, 10'(ex), 10'(ey), ALIGN ? ah : eh, ALIGN ? av : ev, ALIGN ? avo : evo};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL line_step %0d: got %h expected %h", n, got, exp);
      end
      if (ph && !vif.hsync) hs_fall = int'(vif.pixel_x);
      if (!ph && vif.hsync) hs_rise = int'(vif.pixel_x);
      if (pv && !vif.video_on) von_fall = int'(vif.pixel_x);
      if (px == 799 && vif.pixel_x == 10'd0) wrapped = 1'b1;
      ph = vif.hsync;
      pv = vif.video_on;
      px = int'(vif.pixel_x);
    end
    checks++;
    if (!wrapped || vif.pixel_y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: wrapped %b y %0d expected wrapped 1 y 1", wrapped, vif.pixel_y);
    end
    checks++;
    if (hs_fall != 656 + int'(ALIGN)) begin
      errors++;
      $display("FAIL hsync_fall: got x=%0d expected x=%0d", hs_fall, 656 + int'(ALIGN));
    end
    checks++;
    if (hs_rise != 752 + int'(ALIGN)) begin
      errors++;
      $display("FAIL hsync_rise: got x=%0d expected x=%0d", hs_rise, 752 + int'(ALIGN));
    end
    checks++;
    if (von_fall != 640 + int'(ALIGN)) begin
      errors++;
      $display("FAIL video_on_fall: got x=%0d expected x=%0d", von_fall, 640 + int'(ALIGN));
    end
  endtask
  task automatic test_mid_reset();
    int n = 0;
    logic [22:0] got, exp;
    while (!(ex == 300 && ey == 1) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if (vif.pixel_x !== 10'd300 || vif.pixel_y !== 10'd1) begin
      errors++;
      $display("FAIL mid_reset_reach: got (%0d,%0d) expected (300,1)", vif.pixel_x, vif.pixel_y);
    end
    rst_n = 1'b0;
    #1;
    got = {vif.pixel_tick, vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.video_on};
    exp = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", got, exp);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    step();
    checks++;
    if (vif.pixel_tick !== 1'b1 || vif.pixel_x !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_restart_tick: tick %b x %0d expected tick 1 x 0", vif.pixel_tick, vif.pixel_x);
    end
    step();
    checks++;
    if (vif.pixel_x !== 10'd1 || vif.pixel_y !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_restart_x: got (%0d,%0d) expected (1,0)", vif.pixel_x, vif.pixel_y);
    end
  endtask
  task automatic test_clkdiv1_frame();
    int tick_lo = 0, xy_bad = 0, vs_bad = 0, vs_low = 0, p, x, y;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 8100; c++) begin
      @(posedge clk);
      @(negedge clk);
      p = c - 1;
      x = p % H_TOTAL;
      y = (p / H_TOTAL) % FVT;
      if (fif.pixel_tick !== 1'b1) tick_lo++;
      if (fif.pixel_x !== 10'(x) || fif.pixel_y !== 10'(y)) xy_bad++;
      if (x == 400) begin
        if (fif.vsync !== !(y >= 6 && y <= 7)) vs_bad++;
        if (fif.vsync === 1'b0) vs_low++;
      end
      if (c == 8000) begin
        checks++;
        if (fif.pixel_x !== 10'd799 || fif.pixel_y !== 10'd9) begin
          errors++;
          $display("FAIL div1_frame_end: got (%0d,%0d) expected (799,9)", fif.pixel_x, fif.pixel_y);
        end
      end
      if (c == 8001) begin
        checks++;
        if (fif.pixel_x !== 10'd0 || fif.pixel_y !== 10'd0) begin
          errors++;
          $display("FAIL div1_frame_wrap: got (%0d,%0d) expected (0,0)", fif.pixel_x, fif.pixel_y);
        end
      end
    end
    checks++;
    if (tick_lo != 0) begin
      errors++;
      $display("FAIL div1_tick: got %0d low cycles expected 0", tick_lo);
    end
    checks++;
    if (xy_bad != 0) begin
      errors++;
      $display("FAIL div1_counters: got %0d bad cycles expected 0", xy_bad);
    end
    checks++;
    if (vs_bad != 0 || vs_low != 2) begin
      errors++;
      $display("FAIL div1_vsync: bad %0d low_lines %0d expected bad 0 low_lines 2", vs_bad, vs_low);
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_line();
    test_mid_reset();
    test_clkdiv1_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
